// File: rtl/uart_receiver.sv
// 16x-oversampled UART receive engine: 2-FF synchronised rx, start/data/stop FSM, ready/ack host handshake.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk_50mhz,
  input  logic                 rst_n,
  input  logic                 rx_clock_enable,
  input  logic                 rx,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 parity_error
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [3:0]    MID_START = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    MID_BIT   = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [3:0]           samp_cnt_q, samp_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 commit;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
`endif

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM: every transition is qualified by the sample tick.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    commit     = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
`endif
    if (rx_clock_enable) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d    = S_START;
            samp_cnt_d = '0;
          end
        end
        S_START: begin
          if (samp_cnt_q == MID_START) begin
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          if (samp_cnt_q == MID_BIT) begin
            samp_cnt_d         = '0;
            shreg_d[bit_cnt_q] = rx_s_q;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (samp_cnt_q == MID_BIT) begin
            samp_cnt_d = '0;
            par_bit_d  = rx_s_q;
            state_d    = S_STOP;
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
`endif
        S_STOP: begin
          if (samp_cnt_q == MID_BIT) begin
            samp_cnt_d = '0;
            if (rx_s_q) begin
              commit  = 1'b1;
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 4'd1;
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Host handshake: rx_ready rises on commit and stays high until a cycle with
  // rd_ack; an ack coinciding with a commit consumes the old byte, so ready stays.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = commit;
    rx_ready_d = rx_ready_q;
    overrun_d  = overrun_q;
    if (commit) begin
      rx_data_d  = shreg_q;
      rx_ready_d = 1'b1;
      overrun_d  = !rd_ack && (rx_ready_q || overrun_q);
    end else if (rd_ack && rx_ready_q) begin
      rx_ready_d = 1'b0;
      overrun_d  = 1'b0;
    end
`ifdef UART_RX_PARITY_EN
    perr_d = commit && ((^shreg_q) ^ par_bit_q ^ PARITY_ODD);
`endif
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ready_q <= rx_ready_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_ready      = rx_ready_q;
  assign framing_error = ferr_q;
  assign overrun_error = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = perr_q;
`else
  // Parity sense is meaningless without the parity stage; output is constant 0.
  assign parity_error  = PARITY_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: bit-level serial driver, 27-clk tick generator,
// frame-level reference model feeding an expected queue, and a monitor that checks every rx_valid.
module tb_uart_receiver;

  localparam int BIT_CLKS   = 432;
  localparam int HALF_CLKS  = 216;
  localparam bit PARITY_ODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk_50mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_clock_enable = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, framing_error, overrun_error, parity_error;

  logic       auto_ack = 1'b0;
  logic       ack_req = 1'b0;
  int         n_total = 0;
  int         n_bad = 0;
  int         exp_ferr = 0;
  int         ferr_seen = 0;
  logic [8:0] exp_q[$];

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(PARITY_ODD)) dut (
    .clk_50mhz(clk_50mhz),
    .rst_n(rst_n),
    .rx_clock_enable(rx_clock_enable),
    .rx(rx),
    .rd_ack(rd_ack),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error),
    .parity_error(parity_error)
  );

  // Clock and reset-independent tick generator
  always #10 clk_50mhz = ~clk_50mhz;

  initial begin
    forever begin
      repeat (26) @(negedge clk_50mhz);
      rx_clock_enable = 1'b1;
      @(negedge clk_50mhz);
      rx_clock_enable = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk_50mhz);
      #1;
      rd_ack = ack_req || (auto_ack && rx_ready);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic hold_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk_50mhz);
  endtask

  task automatic idle_bits(input int n);
    hold_bit(1'b1, n * BIT_CLKS);
  endtask

  task automatic do_ack();
    @(negedge clk_50mhz);
    ack_req = 1'b1;
    @(negedge clk_50mhz);
    ack_req = 1'b0;
    repeat (3) @(negedge clk_50mhz);
  endtask

  // Reference model: a frame with a good stop bit yields its byte, flagged if
  // the data plus sent parity bit do not have the configured parity.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit bad_par);
    logic p;
    logic perr_exp;
    p = (^d) ^ PARITY_ODD ^ bad_par;
    perr_exp = PAR_EN && (((^d) ^ p) != PARITY_ODD);
    if (stop_ok) exp_q.push_back({perr_exp, d});
    else exp_ferr++;
    hold_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold_bit(d[i], BIT_CLKS);
    if (PAR_EN) hold_bit(p, BIT_CLKS);
    hold_bit(stop_ok, BIT_CLKS);
  endtask

  // Scoreboard monitor
  always @(negedge clk_50mhz) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_valid: got data %0h with no frame expected", rx_data);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
          check("parity_error_at_valid", {31'd0, parity_error}, {31'd0, e[8]});
          check("rx_ready_at_valid", {31'd0, rx_ready}, 32'd1);
        end
      end else if (parity_error) begin
        n_total++;
        n_bad++;
        $display("FAIL parity_without_valid: got 1 expected 0");
      end
      if (framing_error) ferr_seen++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
    check({tag, "_framing"}, {31'd0, framing_error}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun_error}, 32'd0);
    check({tag, "_parity"}, {31'd0, parity_error}, 32'd0);
  endtask

  initial begin
    #(20 * 120000);
    n_total++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk_50mhz);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle_bits(2);

    // single byte with idle around it
    send_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(2);
    check("t1_ready", {31'd0, rx_ready}, 32'd1);
    check("t1_overrun", {31'd0, overrun_error}, 32'd0);
    do_ack();
    check("t1_ready_after_ack", {31'd0, rx_ready}, 32'd0);

    // back-to-back with acks
    auto_ack = 1'b1;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    check("t2_overrun", {31'd0, overrun_error}, 32'd0);
    check("t2_ready", {31'd0, rx_ready}, 32'd0);

    // overrun
    auto_ack = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle_bits(2);
    check("t3_data", {24'd0, rx_data}, 32'hC3);
    check("t3_overrun", {31'd0, overrun_error}, 32'd1);
    check("t3_ready", {31'd0, rx_ready}, 32'd1);
    do_ack();
    check("t3_ready_after_ack", {31'd0, rx_ready}, 32'd0);
    check("t3_overrun_after_ack", {31'd0, overrun_error}, 32'd0);

    // glitch shorter than half a bit
    hold_bit(1'b0, 100);
    idle_bits(2);
    check("t4_no_ready", {31'd0, rx_ready}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b0);
    idle_bits(2);
    check("t4_data", {24'd0, rx_data}, 32'h55);
    do_ack();

    // framing error then break
    send_frame(8'h81, 1'b0, 1'b0);
    hold_bit(1'b0, 19 * BIT_CLKS);
    idle_bits(2);
    check("t5_ferr_count", ferr_seen, exp_ferr);
    check("t5_no_ready", {31'd0, rx_ready}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle_bits(2);
    check("t5_data", {24'd0, rx_data}, 32'h7E);
    check("t5_ready", {31'd0, rx_ready}, 32'd1);

    // reset mid-frame at bit 4 of 0x96
    begin
      logic [7:0] d;
      d = 8'h96;
      hold_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) hold_bit(d[i], BIT_CLKS);
      hold_bit(d[4], HALF_CLKS);
    end
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    check_all_zero("t6_reset");
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h69, 1'b1, 1'b0);
    idle_bits(2);
    check("t6_data", {24'd0, rx_data}, 32'h69);
    do_ack();

    if (PAR_EN) begin
      send_frame(8'h96, 1'b1, 1'b1);
      idle_bits(2);
      do_ack();
    end

    // randomized frames with 0 or 1 idle bit between them
    auto_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      int gap;
      d = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 1);
      send_frame(d, 1'b1, PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0);
      if (gap != 0) idle_bits(gap);
    end
    idle_bits(2);
    check("final_overrun", {31'd0, overrun_error}, 32'd0);

    check("final_queue_empty", exp_q.size(), 32'd0);
    check("final_ferr_count", ferr_seen, exp_ferr);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
